// File: rtl/osfm_pp_resolve_mac_pkg.sv
// rtl/osfm_pp_resolve_mac_pkg.sv - shared widths, types and helpers for the OSFM resolve/MAC slice
`ifndef OSFM_BITWIDTH_I
`define OSFM_BITWIDTH_I 8
`endif

package osfm_pkg;

  localparam int OSFM_BITWIDTH = `OSFM_BITWIDTH_I;
  localparam int OSFM_ACC_W    = 24;
  localparam int OSFM_CNT_W    = 8;

  function automatic int pw_of(input int b);
    return 2 * b;
  endfunction

  typedef logic [OSFM_ACC_W-1:0] acc_t;
  typedef logic [OSFM_CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [OSFM_BITWIDTH-1:0] lo;
    logic                     c1;
    logic [OSFM_BITWIDTH-1:0] hi0;
    logic [OSFM_BITWIDTH-1:0] hi1;
    logic                     last;
    logic                     vld;
  } stage_t;

endpackage

// File: rtl/osfm_pp_resolve_mac_split_cpa.sv
// rtl/osfm_pp_resolve_mac_split_cpa.sv - two-stage split carry-propagate adder resolving sum/carry rows
module osfm_split_cpa
  import osfm_pkg::*;
#(
  parameter int  B   = OSFM_BITWIDTH,
  parameter int  LSC = 0,
  localparam int PW  = pw_of(B)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_vld,
  input  logic [PW-1:0] in_row0,
  input  logic [PW-1:0] in_row1,
  input  logic          in_last,
  output logic          out_vld,
  output logic [PW-1:0] out_prod,
  output logic          out_last
);

  typedef struct packed {
    logic [B-1:0] lo;
    logic         c1;
    logic [B-1:0] hi0;
    logic [B-1:0] hi1;
    logic         last;
    logic         vld;
  } s1_t;

  // Columns below LSC are not part of the kept product.
  localparam logic [PW-1:0] KEEP = {PW{1'b1}} << LSC;

  logic [PW-1:0] r0_m, r1_m;
  logic [B:0]    lo_sum;
  logic [B-1:0]  hi_sum;
  s1_t           s1_d, s1_q;
  logic [PW-1:0] prod_d, prod_q;
  logic          last_q, vld_q;

  always_comb begin
    r0_m        = in_row0 & KEEP;
    r1_m        = in_row1 & KEEP;
    lo_sum      = {1'b0, r0_m[B-1:0]} + {1'b0, r1_m[B-1:0]};
    s1_d        = '0;
    s1_d.lo     = lo_sum[B-1:0];
    s1_d.c1     = lo_sum[B];
    s1_d.hi0    = r0_m[PW-1:B];
    s1_d.hi1    = r1_m[PW-1:B];
    s1_d.last   = in_last;
    s1_d.vld    = in_vld;
    hi_sum      = s1_q.hi0 + s1_q.hi1 + {{(B-1){1'b0}}, s1_q.c1};
    prod_d      = {hi_sum, s1_q.lo};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      prod_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else if (en) begin
      s1_q   <= s1_d;
      prod_q <= prod_d;
      last_q <= s1_q.last;
      vld_q  <= s1_q.vld;
    end
  end

  assign out_vld  = vld_q;
  assign out_prod = prod_q;
  assign out_last = last_q;

endmodule

// File: rtl/osfm_pp_resolve_mac.sv
// rtl/osfm_pp_resolve_mac.sv - resolves sum/carry rows and accumulates dot products
// OSFM_ACC_SATURATE_EN selects a clamping accumulator instead of a wrapping one.
`ifndef OSFM_BITWIDTH_I
`define OSFM_BITWIDTH_I 8
`endif

module osfm_pp_resolve_mac
  import osfm_pkg::*;
#(
  parameter int  BITWIDTH       = `OSFM_BITWIDTH_I,
  parameter int  LEASTSIGNIFCOL = 0,
  parameter int  ACC_W          = 24,
  parameter int  CNT_W          = 8,
  localparam int PW             = pw_of(BITWIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_row0,
  input  logic [PW-1:0]    in_row1,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_overflow
);

  logic             adv;
  logic             s2_vld, s2_last;
  logic [PW-1:0]    s2_prod;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_q, acc_d, acc_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic             ovf_q, ovf_d, ovf_nx;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_ovf_q, out_ovf_d;

  // A held, unaccepted result freezes every stage at once.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  osfm_split_cpa #(
    .B   (BITWIDTH),
    .LSC (LEASTSIGNIFCOL)
  ) u_cpa (
    .clk      (clk),
    .rst      (rst),
    .en       (adv),
    .in_vld   (in_valid),
    .in_row0  (in_row0),
    .in_row1  (in_row1),
    .in_last  (in_last),
    .out_vld  (s2_vld),
    .out_prod (s2_prod),
    .out_last (s2_last)
  );

  always_comb begin
    sum    = {1'b0, acc_q} + {{(ACC_W + 1 - PW){1'b0}}, s2_prod};
`ifdef OSFM_ACC_SATURATE_EN
    acc_nx = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nx = sum[ACC_W-1:0];
`endif
    ovf_nx = ovf_q | sum[ACC_W];
    cnt_nx = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (adv && s2_vld) begin
      if (s2_last) begin
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        out_acc_d   = acc_nx;
        out_beats_d = cnt_nx;
        out_ovf_d   = ovf_nx;
      end else begin
        acc_d = acc_nx;
        cnt_d = cnt_nx;
        ovf_d = ovf_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_acc      = out_acc_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_osfm_pp_resolve_mac.sv
// tb/tb_osfm_pp_resolve_mac.sv - scoreboard bench: two instances (LSC=0/ACC_W=17, LSC=4/ACC_W=24) on shared stimulus
module tb_osfm_pp_resolve_mac;

  logic        clk, rst;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_row0, in_row1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [16:0] out_acc0;
  logic [23:0] out_acc1;
  logic [7:0]  beats0, beats1;

  int checks = 0;
  int failures = 0;
  bit hold_ready = 0;
  bit rand_ready = 0;

  longint     tot[2];
  int         nb[2];
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  osfm_pp_resolve_mac #(.BITWIDTH(8), .LEASTSIGNIFCOL(0), .ACC_W(17), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_row0(in_row0),
    .in_row1(in_row1), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_acc(out_acc0), .out_beats(beats0), .out_overflow(ovf0));

  osfm_pp_resolve_mac #(.BITWIDTH(8), .LEASTSIGNIFCOL(4), .ACC_W(24), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_row0(in_row0),
    .in_row1(in_row1), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_acc(out_acc1), .out_beats(beats1), .out_overflow(ovf1));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int prod(input int r0, input int r1, input int lsc);
    int m;
    m = 'hFFFF & ~((1 << lsc) - 1);
    return ((r0 & m) + (r1 & m)) & 'hFFFF;
  endfunction

  function automatic logic [63:0] expect_res(input longint total, input int n, input int accw);
    longint lim, acc;
    logic ovf;
    logic [7:0] bts;
    lim = longint'(1) << accw;
    ovf = (total >= lim);
`ifdef OSFM_ACC_SATURATE_EN
    acc = ovf ? lim - 1 : total;
`else
    acc = total % lim;
`endif
    bts = (n > 255) ? 8'd255 : n[7:0];
    return {23'b0, ovf, bts, acc[31:0]};
  endfunction

  task automatic record(input int r0, input int r1, input bit last);
    int lsc[2];
    int aw[2];
    lsc = '{0, 4};
    aw  = '{17, 24};
    for (int i = 0; i < 2; i++) begin
      tot[i] += prod(r0, r1, lsc[i]);
      nb[i]++;
      if (last) begin
        if (i == 0) q0.push_back(expect_res(tot[i], nb[i], aw[i]));
        else        q1.push_back(expect_res(tot[i], nb[i], aw[i]));
        tot[i] = 0;
        nb[i]  = 0;
      end
    end
  endtask

  task automatic send(input int r0, input int r1, input bit last);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_row0  = r0[15:0];
    in_row1  = r1[15:0];
    in_last  = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready0 && in_ready1;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (ok) record(r0, r1, last);
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) chk("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_ready) out_ready = 0;
      else if (rand_ready) out_ready = ($urandom_range(3) != 0);
      else out_ready = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("unexpected_out0", 1, 0);
        else chk("result0", {23'b0, ovf0, beats0, 15'b0, out_acc0}, q0.pop_front());
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("unexpected_out1", 1, 0);
        else chk("result1", {23'b0, ovf1, beats1, 8'b0, out_acc1}, q1.pop_front());
      end
    end
  end

  initial begin
    int n;
    bit seen;
    logic [16:0] held;
    tot = '{0, 0};
    nb  = '{0, 0};
    rst = 1; in_valid = 0; in_last = 0; in_row0 = 0; in_row1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {out_valid0, out_valid1}, 0);
    chk("rst_out_acc", {out_acc0, out_acc1}, 0);
    chk("rst_beats_ovf", {beats0, beats1, ovf0, ovf1}, 0);
    chk("rst_in_ready", {in_ready0, in_ready1}, 2'b11);
    rst = 0;
    @(posedge clk); #1;

    send('h00F0, 'h0010, 1);
    n = 1; seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid0) seen = 1;
      else begin @(posedge clk); n++; end
    end
    chk("latency", n, 3);
    chk("lat_acc0", out_acc0, 'h100);
    chk("lat_acc1", out_acc1, 'h100);
    drain();

    send('h000F, 'h0003, 1);
    for (int i = 0; i < 4; i++) send('h0100, 'h0100, i == 3);
    for (int i = 0; i < 3; i++) send('hFFFF, 'hFFFF, i == 2);
    drain();

    hold_ready = 1;
    send(4, 0, 0);
    send(3, 3, 1);
    send(10, 10, 1);
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (out_valid0) seen = 1;
    end
    chk("stall_seen", seen, 1);
    held = out_acc0;
    chk("stall_first", held, 10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready0, 0);
      chk("stall_acc_stable", out_acc0, held);
      chk("stall_valid_held", out_valid0, 1);
    end
    hold_ready = 0;
    drain();

    send(1, 0, 0);
    send(1, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    tot = '{0, 0};
    nb  = '{0, 0};
    chk("midrst_outputs", {out_valid0, out_acc0, beats0, ovf0}, 0);
    send(1, 2, 1);
    drain();

    for (int i = 0; i < 300; i++) send(1, 0, i == 299);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
      send($urandom & 'hFFFF, $urandom & 'hFFFF, (i == 399) || ($urandom_range(4) == 0));
    end
    drain();
    rand_ready = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
